// File: rtl/eth_pkt_buf_writer.sv
// eth_pkt_buf_writer: writes Ethernet flits into the eSRAM packet buffer and queues packet descriptors.
// Statistics counters are built only when PKT_BUF_STATS_EN is defined.
module eth_pkt_buf_writer #(
    parameter int ADDR_W        = 17,
    parameter int MAX_PKT_FLITS = 32,
    parameter int DESC_DEPTH    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic              in_valid,
    input  logic [511:0]      in_data,
    input  logic [5:0]        in_empty,
    output logic              in_almost_full,
    output logic              esram_pkt_buf_wren,
    output logic [ADDR_W-1:0] esram_pkt_buf_wraddress,
    output logic [519:0]      esram_pkt_buf_wrdata,
    input  logic              free_valid,
    input  logic [5:0]        free_flits,
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [ADDR_W-1:0] desc_addr,
    output logic [5:0]        desc_flits,
    output logic [15:0]       desc_bytes,
    output logic [31:0]       stat_pkt_cnt,
    output logic [31:0]       stat_drop_cnt
);
    localparam int CW = $clog2(DESC_DEPTH);
    localparam int DW = ADDR_W + 22;
    localparam logic [ADDR_W:0] SPAN  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] MAXF  = (ADDR_W+1)'(MAX_PKT_FLITS);
    localparam logic [ADDR_W:0] MAXF2 = (ADDR_W+1)'(2 * MAX_PKT_FLITS);
    localparam logic [5:0]      MAXC  = 6'(MAX_PKT_FLITS);
    localparam logic [CW:0]     DEPC  = (CW+1)'(DESC_DEPTH);
    localparam logic [CW:0]     AFC   = (CW+1)'(DESC_DEPTH - 2);

    typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, start_q, start_d, ptr_b;
    logic [ADDR_W:0]   used_q, used_d, used_b;
    logic [5:0]        cnt_q, cnt_d, nf;
    logic [15:0]       bytes;
    logic [CW:0]       fcnt_q, eff;
    logic [CW-1:0]     wp_q, rd_q;
    logic [DW-1:0]     pd_q;
    logic [DW-1:0]     mem [DESC_DEPTH];
    logic              rb, ok, wr, push, push_q, pop;
    logic              wren_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [519:0]      wdata_q;

    // A restarting sop sees the buffer as if the aborted packet had never been written.
    always_comb begin
        rb      = state_q == PKT && in_valid && (in_sop || cnt_q == MAXC);
        ptr_b   = rb ? start_q : wr_ptr_q;
        used_b  = rb ? used_q - (ADDR_W+1)'(cnt_q) : used_q;
        eff     = fcnt_q + (CW+1)'(push_q);
        ok      = (SPAN - used_b) >= MAXF && eff < DEPC;
        wr      = in_valid && (in_sop ? ok : state_q == PKT && cnt_q != MAXC);
        push    = wr && in_eop;
        nf      = in_sop ? 6'd1 : cnt_q + 6'd1;
        bytes   = {4'b0, nf, 6'b0} - {10'b0, in_empty};
        cnt_d   = wr ? nf : cnt_q;
        start_d = (in_valid && in_sop && ok) ? ptr_b : start_q;
        wr_ptr_d = ptr_b + ADDR_W'(wr);
        used_d  = used_b + (ADDR_W+1)'(wr) - (free_valid ? (ADDR_W+1)'(free_flits) : '0);
        state_d = !in_valid ? state_q :
                  in_eop ? IDLE :
                  in_sop ? (ok ? PKT : DROP) :
                  (state_q == PKT && cnt_q == MAXC) ? DROP : state_q;
        pop     = desc_valid && desc_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            start_q  <= '0;
            used_q   <= '0;
            cnt_q    <= '0;
            wren_q   <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            push_q   <= 1'b0;
            pd_q     <= '0;
            wp_q     <= '0;
            rd_q     <= '0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            start_q  <= start_d;
            used_q   <= used_d;
            cnt_q    <= cnt_d;
            wren_q   <= wr;
            if (wr) begin
                waddr_q <= ptr_b;
                wdata_q <= {in_sop, in_eop, in_empty, in_data};
            end
            push_q <= push;
            if (push) pd_q <= {in_sop ? ptr_b : start_q, nf, bytes};
            if (push_q) wp_q <= wp_q + CW'(1);
            if (pop) rd_q <= rd_q + CW'(1);
            fcnt_q <= fcnt_q + (CW+1)'(push_q) - (CW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_q) mem[wp_q] <= pd_q;
    end

    assign desc_valid = fcnt_q != '0;
    assign {desc_addr, desc_flits, desc_bytes} = desc_valid ? mem[rd_q] : '0;
    assign in_almost_full = (SPAN - used_q) < MAXF2 || fcnt_q >= AFC;
    assign esram_pkt_buf_wren = wren_q;
    assign esram_pkt_buf_wraddress = waddr_q;
    assign esram_pkt_buf_wrdata = wdata_q;

`ifdef PKT_BUF_STATS_EN
    logic [31:0] pkt_q, pkt_d, drop_q, drop_d;
    logic [32:0] pkt_s, drop_s;
    logic [1:0]  dinc;
    // An aborted packet and a refused restart in the same cycle count as two drops.
    assign dinc   = {1'b0, rb} + {1'b0, in_valid && in_sop && !ok};
    assign pkt_s  = {1'b0, pkt_q} + 33'(push);
    assign drop_s = {1'b0, drop_q} + 33'(dinc);
    assign pkt_d  = pkt_s[32] ? '1 : pkt_s[31:0];
    assign drop_d = drop_s[32] ? '1 : drop_s[31:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q  <= '0;
            drop_q <= '0;
        end else begin
            pkt_q  <= pkt_d;
            drop_q <= drop_d;
        end
    end
    assign stat_pkt_cnt  = pkt_q;
    assign stat_drop_cnt = drop_q;
`else
    assign stat_pkt_cnt  = '0;
    assign stat_drop_cnt = '0;
`endif
endmodule

// File: tb/tb_eth_pkt_buf_writer.sv
// tb_eth_pkt_buf_writer: scoreboard bench for eth_pkt_buf_writer (ADDR_W=6, 32-flit packets, 8 descriptors).
module tb_eth_pkt_buf_writer;
`ifdef PKT_BUF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic         clk, rst_n;
    logic         in_sop, in_eop, in_valid;
    logic [511:0] in_data;
    logic [5:0]   in_empty;
    logic         in_almost_full;
    logic         wren;
    logic [5:0]   waddr;
    logic [519:0] wdata;
    logic         free_valid;
    logic [5:0]   free_flits;
    logic         desc_valid, desc_ready;
    logic [5:0]   desc_addr, desc_flits;
    logic [15:0]  desc_bytes;
    logic [31:0]  stat_pkt_cnt, stat_drop_cnt;

    int checks = 0, fails = 0, exp_pkt = 0, exp_drop = 0;
    logic [5:0]   wa_q [$];
    logic [519:0] wd_q [$];
    logic [27:0]  dq [$];
    logic [5:0]   ea;
    logic [519:0] ed;
    logic [27:0]  edsc;

    eth_pkt_buf_writer #(.ADDR_W(6), .MAX_PKT_FLITS(32), .DESC_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_sop(in_sop), .in_eop(in_eop), .in_valid(in_valid),
        .in_data(in_data), .in_empty(in_empty), .in_almost_full(in_almost_full),
        .esram_pkt_buf_wren(wren), .esram_pkt_buf_wraddress(waddr), .esram_pkt_buf_wrdata(wdata),
        .free_valid(free_valid), .free_flits(free_flits),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_addr(desc_addr), .desc_flits(desc_flits), .desc_bytes(desc_bytes),
        .stat_pkt_cnt(stat_pkt_cnt), .stat_drop_cnt(stat_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", n, a, e);
        end
    endtask

    task automatic flit(input bit s, input bit e, input logic [5:0] emp, input logic [31:0] tag,
                        input bit w, input int a);
        in_valid = 1'b1; in_sop = s; in_eop = e; in_empty = emp; in_data = {16{tag}};
        if (w) begin
            wa_q.push_back(6'(a % 64));
            wd_q.push_back({s, e, emp, {16{tag}}});
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic pkt(input int n, input logic [5:0] emp, input logic [31:0] tag, input bit adm,
                       input int start, input logic [15:0] bytes);
        for (int i = 0; i < n; i++)
            flit(i == 0, i == n - 1, (i == n - 1) ? emp : 6'd0, tag + 32'(i), adm && i < 32, start + i);
        if (adm && n <= 32) begin
            dq.push_back({6'(start % 64), 6'(n), bytes});
            exp_pkt++;
        end else exp_drop++;
    endtask

    task automatic free(input int n);
        free_valid = 1'b1; free_flits = 6'(n);
        @(posedge clk); #1;
        free_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (dq.size() != 0 || wa_q.size() != 0); i++) @(posedge clk);
        #1;
        chk("drain_desc", dq.size(), 0);
        chk("drain_wr", wa_q.size(), 0);
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_wren"}, wren, 0);
        chk({n, "_waddr"}, waddr, 0);
        chk({n, "_wdata"}, wdata != '0, 0);
        chk({n, "_dvalid"}, desc_valid, 0);
        chk({n, "_afull"}, in_almost_full, 0);
        chk({n, "_pkt"}, stat_pkt_cnt, 0);
        chk({n, "_drop"}, stat_drop_cnt, 0);
    endtask

    task automatic chk_stats(input string n);
        chk({n, "_pkt"}, stat_pkt_cnt, STATS ? exp_pkt : 0);
        chk({n, "_drop"}, stat_drop_cnt, STATS ? exp_drop : 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (wren) begin
                if (wa_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL wr_unexpected actual=%0h required=none", waddr);
                end else begin
                    ea = wa_q.pop_front();
                    ed = wd_q.pop_front();
                    chk("wr_addr", waddr, ea);
                    checks++;
                    if (wdata !== ed) begin
                        fails++;
                        $display("FAIL wr_data actual=%0h required=%0h", wdata, ed);
                    end
                end
            end
            if (desc_valid && desc_ready) begin
                if (dq.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL desc_unexpected actual=%0h required=none", {desc_addr, desc_flits, desc_bytes});
                end else begin
                    edsc = dq.pop_front();
                    chk("desc", {desc_addr, desc_flits, desc_bytes}, edsc);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; in_empty = '0;
        free_valid = 1'b0; free_flits = '0; desc_ready = 1'b0;
        #1 chk_zero("rst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_afull", in_almost_full, 0);
        chk("idle_dvalid", desc_valid, 0);
        // 3-flit packet: addresses 0..2, descriptor two cycles after eop
        pkt(3, 6'd10, 32'h100, 1, 0, 16'd182);
        chk("t1_dvalid_t1", desc_valid, 0);
        chk("t1_afull", in_almost_full, 1);
        @(posedge clk); #1;
        chk("t1_dvalid_t2", desc_valid, 1);
        chk("t1_bytes", desc_bytes, 182);
        desc_ready = 1'b1;
        free(3);
        drain();
        chk_stats("t1");
        // oversize packet rolls back, next packet reuses its start
        pkt(33, 6'd0, 32'h200, 1, 3, 16'd0);
        drain();
        chk_stats("t2");
        pkt(1, 6'd0, 32'h300, 1, 3, 16'd64);
        free(1);
        // sop without eop aborts and restarts at the same address
        flit(1, 0, 6'd0, 32'h400, 1, 4);
        flit(0, 0, 6'd0, 32'h401, 1, 5);
        exp_drop++;
        pkt(2, 6'd0, 32'h500, 1, 4, 16'd128);
        free(2);
        // stray flits in IDLE are discarded
        flit(0, 0, 6'd0, 32'h600, 0, 0);
        flit(0, 1, 6'd3, 32'h601, 0, 0);
        // address wrap
        pkt(28, 6'd0, 32'h700, 1, 6, 16'd1792);
        free(28);
        pkt(28, 6'd0, 32'h800, 1, 34, 16'd1792);
        free(28);
        pkt(4, 6'd5, 32'h900, 1, 62, 16'd251);
        free(4);
        drain();
        chk_stats("t5");
        // descriptor FIFO full
        desc_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            pkt(1, 6'(i), 32'hA00 + 32'(i * 16), 1, 2 + i, 16'(64 - i));
        chk("t6_afull", in_almost_full, 1);
        pkt(1, 6'd0, 32'hB00, 0, 0, 16'd0);
        chk_stats("t6_full");
        desc_ready = 1'b1;
        @(posedge clk); #1;
        desc_ready = 1'b0;
        pkt(1, 6'd1, 32'hC00, 1, 10, 16'd63);
        desc_ready = 1'b1;
        @(posedge clk); #1;
        desc_ready = 1'b0;
        pkt(1, 6'd2, 32'hD00, 1, 11, 16'd62);
        pkt(2, 6'd0, 32'hE00, 0, 0, 16'd0);
        chk_stats("t6_pushpop");
        desc_ready = 1'b1;
        free(10);
        drain();
        chk("t6_afull_clear", in_almost_full, 0);
        // reset during the second flit of a packet
        flit(1, 0, 6'd0, 32'hF00, 0, 12);
        in_valid = 1'b1; in_data = {16{32'hF01}};
        #1 rst_n = 1'b0;
        #1 chk_zero("mid_rst");
        in_valid = 1'b0;
        exp_pkt = 0; exp_drop = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        pkt(2, 6'd3, 32'h1000, 1, 0, 16'd125);
        drain();
        chk_stats("t7");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
